// File: rtl/cache_bus_arbiter_if.sv
// rtl/cache_bus_arbiter_if.sv - sram-like signal bundle for the i_cache/d_cache to downstream arbiter
// master: the caches plus the downstream port as seen from outside; slave: the arbiter itself.
interface cache_bus_arbiter_if;
    logic        inst_req;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_addr_ok;
    logic        inst_data_ok;

    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_addr_ok;
    logic        data_data_ok;

    logic        cache_req;
    logic        cache_wr;
    logic [1:0]  cache_size;
    logic [31:0] cache_addr;
    logic [31:0] cache_wdata;
    logic [31:0] cache_rdata;
    logic        cache_addr_ok;
    logic        cache_data_ok;

    modport master (
        output inst_req, inst_size, inst_addr,
        input  inst_rdata, inst_addr_ok, inst_data_ok,
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_rdata, data_addr_ok, data_data_ok,
        input  cache_req, cache_wr, cache_size, cache_addr, cache_wdata,
        output cache_rdata, cache_addr_ok, cache_data_ok
    );

    modport slave (
        input  inst_req, inst_size, inst_addr,
        output inst_rdata, inst_addr_ok, inst_data_ok,
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_rdata, data_addr_ok, data_data_ok,
        output cache_req, cache_wr, cache_size, cache_addr, cache_wdata,
        input  cache_rdata, cache_addr_ok, cache_data_ok
    );
endinterface

// File: rtl/cache_bus_arbiter.sv
// rtl/cache_bus_arbiter.sv - merges i_cache and d_cache sram-like ports onto one downstream port
// One transaction outstanding at a time; grant held from acceptance until downstream data_ok.
module cache_bus_arbiter #(
    parameter bit          RR_MODE   = 1'b0,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    cache_bus_arbiter_if.slave   bus,
    output logic [CNT_WIDTH-1:0] inst_grant_cnt,
    output logic [CNT_WIDTH-1:0] data_grant_cnt
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t                 state_q, state_d;
    logic                   owner_q, owner_d;     // 1: d_cache owns the bus
    logic                   last_q, last_d;       // 1: d_cache was granted last
    logic                   wr_q, wr_d;
    logic [1:0]             size_q, size_d;
    logic [31:0]            addr_q, addr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [31:0]            irdata_q, irdata_d;
    logic [31:0]            drdata_q, drdata_d;
    logic [CNT_WIDTH-1:0]   icnt_q, icnt_d;
    logic [CNT_WIDTH-1:0]   dcnt_q, dcnt_d;
    logic                   grant_any;
    logic                   grant_data;
    logic                   done;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        wr_d       = wr_q;
        size_d     = size_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        irdata_d   = irdata_q;
        drdata_d   = drdata_q;
        icnt_d     = icnt_q;
        dcnt_d     = dcnt_q;
        grant_any  = 1'b0;
        grant_data = 1'b0;
        done       = 1'b0;

        case (state_q)
            IDLE: begin
                grant_any = bus.inst_req | bus.data_req;
                if (bus.inst_req && bus.data_req) begin
                    grant_data = RR_MODE ? ~last_q : 1'b1;
                end else begin
                    grant_data = bus.data_req;
                end
                if (grant_any) begin
                    state_d = ADDR;
                    owner_d = grant_data;
                    last_d  = grant_data;
                    if (grant_data) begin
                        wr_d    = bus.data_wr;
                        size_d  = bus.data_size;
                        addr_d  = bus.data_addr;
                        wdata_d = bus.data_wdata;
                        dcnt_d  = dcnt_q + 1'b1;
                    end else begin
                        wr_d    = 1'b0;
                        size_d  = bus.inst_size;
                        addr_d  = bus.inst_addr;
                        wdata_d = 32'h0;
                        icnt_d  = icnt_q + 1'b1;
                    end
                end
            end
            ADDR: begin
                if (bus.cache_addr_ok) begin
                    done    = bus.cache_data_ok;
                    state_d = bus.cache_data_ok ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bus.cache_data_ok) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Read data is captured so each master sees its last completed value while idle.
        if (done) begin
            if (owner_q) begin
                drdata_d = bus.cache_rdata;
            end else begin
                irdata_d = bus.cache_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b0;
            wr_q     <= 1'b0;
            size_q   <= 2'b00;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            irdata_q <= 32'h0;
            drdata_q <= 32'h0;
            icnt_q   <= '0;
            dcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            wr_q     <= wr_d;
            size_q   <= size_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            irdata_q <= irdata_d;
            drdata_q <= drdata_d;
            icnt_q   <= icnt_d;
            dcnt_q   <= dcnt_d;
        end
    end

    // Handshakes are suppressed during reset so an aborted transaction never completes.
    assign bus.inst_addr_ok = !rst && grant_any && !grant_data;
    assign bus.data_addr_ok = !rst && grant_any && grant_data;
    assign bus.inst_data_ok = !rst && done && !owner_q;
    assign bus.data_data_ok = !rst && done && owner_q;
    assign bus.inst_rdata   = bus.inst_data_ok ? bus.cache_rdata : irdata_q;
    assign bus.data_rdata   = bus.data_data_ok ? bus.cache_rdata : drdata_q;

    assign bus.cache_req    = (state_q == ADDR);
    assign bus.cache_wr     = wr_q;
    assign bus.cache_size   = size_q;
    assign bus.cache_addr   = addr_q;
    assign bus.cache_wdata  = wdata_q;

    assign inst_grant_cnt   = icnt_q;
    assign data_grant_cnt   = dcnt_q;
endmodule
